alu_ctrl_seq: RTL

- Registered successor to the combinational D/X ALU-control decode.
- Adds a parametrised instruction width and a multi-cycle mult/div sequencer that issues start pulses, stalls the pipeline and reports completion and errors.
- Sits between the D/X latch and the ALU/multdiv unit.
- Decoded ALU controls are pipelined by one cycle.

---
 rtl/alu_ctrl_seq_if.sv | 32 +++
 rtl/alu_ctrl_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
// D/X-to-ALU control bus for alu_ctrl_seq: instruction in, multdiv handshake, decoded controls out.
interface alu_ctrl_seq_if #(
  parameter int unsigned IR_W = 32
);
  logic [IR_W-1:0] ir_in;
  logic            ir_valid;
  logic            md_rdy;
  logic            md_exc;
  logic [4:0]      alu_op;
  logic [4:0]      sham;
  logic            sx_mux;
  logic            is_branch;
  logic            alu_valid;
  logic            ctrl_mult;
  logic            ctrl_div;
  logic            stall;
  logic            md_done;
  logic            md_err;

  // master drives the instruction and multdiv responses; slave is the control sequencer
  modport master (
    output ir_in, ir_valid, md_rdy, md_exc,
    input  alu_op, sham, sx_mux, is_branch, alu_valid,
    input  ctrl_mult, ctrl_div, stall, md_done, md_err
  );

  modport slave (
    input  ir_in, ir_valid, md_rdy, md_exc,
    output alu_op, sham, sx_mux, is_branch, alu_valid,
    output ctrl_mult, ctrl_div, stall, md_done, md_err
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decode with a mult/div start/stall/complete sequencer.
// Optional macro ALU_CTRL_SEQ_TIMEOUT_EN adds a WAIT timeout that aborts with md_err.
module alu_ctrl_seq #(
  parameter int unsigned IR_W    = 32,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input logic         clock,
  input logic         reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned OP_W = 5;
  localparam int unsigned FW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Elaboration-time guard on the parameter set
  if (IR_W < 32 || (64'(1) << CNT_W) <= 64'(TIMEOUT) || TIMEOUT < 1) begin : g_bad_params
    $error("alu_ctrl_seq: needs IR_W >= 32, TIMEOUT >= 1 and 2**CNT_W > TIMEOUT");
  end

  state_e          state_q;
  logic [FW-1:0]   alu_op_q;
  logic [FW-1:0]   sham_q;
  logic            sx_mux_q;
  logic            is_branch_q;
  logic            alu_valid_q;
  logic            ctrl_mult_q;
  logic            ctrl_div_q;
  logic            stall_q;
  logic            md_done_q;
  logic            md_err_q;
`ifdef ALU_CTRL_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
`endif

  logic [OP_W-1:0] op;
  logic [FW-1:0]   fld;
  logic [FW-1:0]   shamt;
  logic            dec_md;
  logic            dec_br;
  logic            dec_alu;
  logic [FW-1:0]   dec_alu_op;
  logic [FW-1:0]   dec_sham;
  logic            dec_sx;
  logic            capture;
  logic            unused_ir;

  assign op        = bus.ir_in[IR_W-1 -: OP_W];
  assign fld       = bus.ir_in[6:2];
  assign shamt     = bus.ir_in[11:7];
  assign unused_ir = ^{bus.ir_in[IR_W-OP_W-1:12], bus.ir_in[1:0]};

  // Instruction decode
  always_comb begin
    dec_md     = (op == 5'd0) && (fld == 5'd6 || fld == 5'd7);
    dec_br     = (op == 5'd2) || (op == 5'd6) || (op == 5'd22);
    dec_alu    = (op == 5'd0) && !dec_md;
    dec_alu_op = dec_alu ? fld : (dec_br ? 5'd1 : 5'd0);
    dec_sham   = (op == 5'd0) ? shamt : 5'd0;
    dec_sx     = (op != 5'd0) && (op != 5'd2) && (op != 5'd6);
  end

  // stall_q mirrors state in {ISSUE, WAIT}, so this also blocks capture while stalled
  assign capture = bus.ir_valid && !stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      alu_op_q    <= '0;
      sham_q      <= '0;
      sx_mux_q    <= 1'b0;
      is_branch_q <= 1'b0;
      alu_valid_q <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      stall_q     <= 1'b0;
      md_done_q   <= 1'b0;
      md_err_q    <= 1'b0;
`ifdef ALU_CTRL_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      alu_valid_q <= capture;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      md_done_q   <= 1'b0;

      if (capture) begin
        alu_op_q    <= dec_alu_op;
        sham_q      <= dec_sham;
        sx_mux_q    <= dec_sx;
        is_branch_q <= dec_br;
      end

      case (state_q)
        IDLE, DONE: begin
          // Start pulse is issued straight from the capture edge, so it also records the kind
          if (capture && dec_md) begin
            state_q     <= ISSUE;
            stall_q     <= 1'b1;
            md_err_q    <= 1'b0;
            ctrl_mult_q <= ~fld[0];
            ctrl_div_q  <= fld[0];
          end else begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          stall_q <= 1'b1;
`ifdef ALU_CTRL_SEQ_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (bus.md_rdy) begin
            state_q   <= DONE;
            stall_q   <= 1'b0;
            md_done_q <= 1'b1;
            md_err_q  <= bus.md_exc;
`ifdef ALU_CTRL_SEQ_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            stall_q   <= 1'b0;
            md_done_q <= 1'b1;
            md_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_op    = alu_op_q;
  assign bus.sham      = sham_q;
  assign bus.sx_mux    = sx_mux_q;
  assign bus.is_branch = is_branch_q;
  assign bus.alu_valid = alu_valid_q;
  assign bus.ctrl_mult = ctrl_mult_q;
  assign bus.ctrl_div  = ctrl_div_q;
  assign bus.stall     = stall_q;
  assign bus.md_done   = md_done_q;
  assign bus.md_err    = md_err_q;

endmodule
